// File: rtl/simplebus_arbiter.sv
// rtl/simplebus_arbiter.sv - round-robin owner arbiter for a shared simple bus
//
// Grants one of NREQ requesters exclusive ownership of the bus, drives the bus
// from the owner's data slice, bounds each grant to MAXHOLD cycles, and puts a
// one-cycle turnaround (GAP) plus one arbitration cycle (IDLE) between owners.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester level request
//   done       per-requester transfer-complete strobe (only done[owner] used)
//   data_in    per-requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt        registered one-hot grant
//   owner      registered index of the current grantee
//   bus_out    registered bus data (owner's slice, one cycle late)
//   bus_valid  high while a grant is active
//   timeout    one-cycle pulse in GAP when the hold limit alone ended a grant

module simplebus_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MAXHOLD = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           done,
    input  logic [NREQ*WIDTH-1:0]     data_in,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [WIDTH-1:0]          bus_out,
    output logic                      bus_valid,
    output logic                      timeout
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAXHOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]   bus_out_q, bus_out_d;
    logic               bus_valid_q, bus_valid_d;
    logic               timeout_q, timeout_d;

    // Round-robin search: first set request strictly after last grantee, wrapping.
    logic               win_found;
    logic [OW-1:0]      win_idx;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    logic rel_done, rel_drop, rel_hold;

    always_comb begin
        rel_done = done[owner_q];
        rel_drop = !req[owner_q];
        rel_hold = (hold_cnt_q == HW'(MAXHOLD - 1));
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt_d       = '0;
                bus_valid_d = 1'b0;
                bus_out_d   = '0;
                if (win_found) begin
                    state_d          = S_BUSY;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    owner_d          = win_idx;
                    last_d           = win_idx;
                    hold_cnt_d       = '0;
                    bus_valid_d      = 1'b1;
                    bus_out_d        = data_in[int'(win_idx)*WIDTH +: WIDTH];
                end
            end

            S_BUSY: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_d     = S_GAP;
                    gnt_d       = '0;
                    bus_valid_d = 1'b0;
                    bus_out_d   = '0;
                    // Only flag a timeout when the hold limit was the sole cause.
                    timeout_d   = rel_hold && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HW'(1);
                    bus_out_d   = data_in[int'(owner_q)*WIDTH +: WIDTH];
                end
            end

            S_GAP: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                bus_valid_d = 1'b0;
                bus_out_d   = '0;
            end

            default: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                bus_valid_d = 1'b0;
                bus_out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            last_q      <= OW'(NREQ - 1);
            hold_cnt_q  <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_simplebus_arbiter.sv
// tb/tb_simplebus_arbiter.sv - directed self-checking bench for simplebus_arbiter

module tb_simplebus_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int MAXHOLD = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ-1:0]         done = '0;
    logic [NREQ*WIDTH-1:0]   data_in = '0;
    logic [NREQ-1:0]         gnt;
    logic [1:0]              owner;
    logic [WIDTH-1:0]        bus_out;
    logic                    bus_valid;
    logic                    timeout;

    int passed = 0;
    int total  = 0;

    simplebus_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .MAXHOLD(MAXHOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .data_in(data_in),
        .gnt(gnt),
        .owner(owner),
        .bus_out(bus_out),
        .bus_valid(bus_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_clear(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h0);
        chk({tag, ".owner"}, 32'(owner), 32'h0);
        chk({tag, ".bus_out"}, 32'(bus_out), 32'h0);
        chk({tag, ".bus_valid"}, 32'(bus_valid), 32'h0);
        chk({tag, ".timeout"}, 32'(timeout), 32'h0);
    endtask

    task automatic do_reset;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [WIDTH-1:0] slice_val [NREQ];
    int order [5];

    initial begin
        slice_val[0] = 8'h11;
        slice_val[1] = 8'h22;
        slice_val[2] = 8'h33;
        slice_val[3] = 8'h44;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        // Reset with random inputs: outputs clear before any clock edge
        req     = NREQ'($urandom);
        done    = NREQ'($urandom);
        data_in = $urandom;
        #1 rst = 1'b1;
        #1 outputs_clear("reset");
        req  = '0;
        done = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester
        data_in = {8'h44, 8'h33, 8'hA5, 8'h11};
        req     = 4'b0010;
        tick;
        chk("single.gnt", 32'(gnt), 32'h2);
        chk("single.owner", 32'(owner), 32'h1);
        chk("single.bus_out", 32'(bus_out), 32'hA5);
        chk("single.bus_valid", 32'(bus_valid), 32'h1);
        data_in[15:8] = 8'h5A;
        tick;
        chk("single.lag", 32'(bus_out), 32'h5A);
        chk("single.hold", 32'(gnt), 32'h2);
        done = 4'b0010;
        tick;
        chk("single.gap_gnt", 32'(gnt), 32'h0);
        chk("single.gap_valid", 32'(bus_valid), 32'h0);
        chk("single.gap_bus", 32'(bus_out), 32'h0);
        chk("single.gap_timeout", 32'(timeout), 32'h0);
        done = '0;
        req  = '0;
        tick;
        chk("single.idle_gnt", 32'(gnt), 32'h0);
        tick;
        chk("single.idle_stay", 32'(gnt), 32'h0);

        // Fairness: all requesting, done pulsed on each grant's first cycle
        data_in = {slice_val[3], slice_val[2], slice_val[1], slice_val[0]};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("fair%0d.gnt", k), 32'(gnt), 32'(4'b0001 << order[k]));
            chk($sformatf("fair%0d.owner", k), 32'(owner), 32'(order[k]));
            chk($sformatf("fair%0d.bus_out", k), 32'(bus_out), 32'(slice_val[order[k]]));
            done = 4'b0001 << order[k];
            tick;
            chk($sformatf("fair%0d.gap_valid", k), 32'(bus_valid), 32'h0);
            done = '0;
            tick;
            chk($sformatf("fair%0d.idle_valid", k), 32'(bus_valid), 32'h0);
        end
        req = '0;
        tick;
        chk("fair.settle", 32'(gnt), 32'h0);

        // Timeout: requester 2 holds for MAXHOLD cycles with no done
        req = 4'b0100;
        for (int k = 0; k < MAXHOLD; k++) begin
            tick;
            chk($sformatf("to.hold%0d.gnt", k), 32'(gnt), 32'h4);
            chk($sformatf("to.hold%0d.timeout", k), 32'(timeout), 32'h0);
        end
        tick;
        chk("to.gap_gnt", 32'(gnt), 32'h0);
        chk("to.gap_timeout", 32'(timeout), 32'h1);
        tick;
        chk("to.idle_gnt", 32'(gnt), 32'h0);
        chk("to.idle_timeout", 32'(timeout), 32'h0);
        tick;
        chk("to.regrant", 32'(gnt), 32'h4);

        // done[owner] coinciding with the hold limit: no timeout
        tick;
        tick;
        tick;
        chk("sim_done.last_hold", 32'(gnt), 32'h4);
        done = 4'b0100;
        tick;
        chk("sim_done.gap_gnt", 32'(gnt), 32'h0);
        chk("sim_done.timeout", 32'(timeout), 32'h0);
        done = '0;
        tick;
        tick;
        chk("sim_drop.grant", 32'(gnt), 32'h4);

        // req[owner] dropped at the hold limit: no timeout
        tick;
        tick;
        tick;
        req = '0;
        tick;
        chk("sim_drop.gap_gnt", 32'(gnt), 32'h0);
        chk("sim_drop.timeout", 32'(timeout), 32'h0);
        tick;
        tick;
        chk("sim_drop.idle", 32'(gnt), 32'h0);

        // Reset mid-grant, then first grant goes to requester 0
        req = 4'b0100;
        tick;
        chk("rst_mid.gnt", 32'(gnt), 32'h4);
        #1 rst = 1'b1;
        #1 outputs_clear("rst_mid");
        req = 4'b1001;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid.held", 32'(gnt), 32'h0);
        tick;
        chk("rst_mid.first_gnt", 32'(gnt), 32'h1);
        chk("rst_mid.first_owner", 32'(owner), 32'h0);
        chk("rst_mid.timeout", 32'(timeout), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simplebus_arbiter.md
# simplebus_arbiter

Round-robin arbiter that shares one simple bus between `NREQ` requesters. It grants exclusive ownership to one requester at a time and drives the bus from the owner's data slice. It also enforces a bounded hold time with a timeout flag, and inserts a turnaround gap between owners. It sits between the requesting modules and the shared bus wires that top-level modules carry as `simplebus` interface instances.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; must be at least 2.
- `WIDTH`, default 8: bus data width.
- `MAXHOLD`, default 15: maximum number of consecutive cycles a grant may be held; must be at least 1.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, NREQ: request per requester; level-sensitive.
- `done`, input, NREQ: transfer-complete strobe per requester; only `done[owner]` is examined.
- `data_in`, input, NREQ*WIDTH: per-requester data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `gnt`, output, NREQ: one-hot grant, registered.
- `owner`, output, $clog2(NREQ): index of the current grantee, registered.
- `bus_out`, output, WIDTH: registered bus data.
- `bus_valid`, output, 1: high while a grant is active.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States:
  - IDLE: no grant; arbitrates.
  - BUSY: one requester owns the bus.
  - GAP: one-cycle turnaround; no grant.
- Internal registers:
  - `last`: index of the most recent grantee; resets to NREQ-1, so requester 0 wins first.
  - `hold_cnt`: cycles held in the current grant, width $clog2(MAXHOLD+1).
- IDLE behaviour:
  - If `req` is nonzero, the winner is the first set bit found by searching upward from `(last+1) mod NREQ` with wrap.
  - On the next edge: state becomes BUSY, `gnt` becomes one-hot(winner), `owner` and `last` become the winner, and `hold_cnt` becomes 0.
  - If `req` is zero, the arbiter stays in IDLE.
- BUSY behaviour:
  - `bus_out` loads `data_in` slice `owner` on every edge that ends in BUSY, including the entry edge.
  - `bus_valid` is 1.
  - The grant is released when any of these holds in the current cycle:
    - `done[owner]` is 1;
    - `req[owner]` is 0;
    - `hold_cnt == MAXHOLD-1`.
  - If no release condition holds, `hold_cnt` increments and the arbiter stays in BUSY.
  - On release the next state is GAP.
- GAP behaviour:
  - `gnt` is 0, `bus_valid` is 0, and `bus_out` is 0.
  - `timeout` is 1 only if the release was caused solely by the hold limit, i.e. `done[owner]` and `~req[owner]` were both 0 in the release cycle.
  - The next state is always IDLE.
- Changes to `req` or `done` for non-owners are ignored during BUSY and GAP.
- Reset:
  - Takes effect immediately and asynchronously.
  - Forces state IDLE, all outputs 0 (`gnt`, `owner`, `bus_out`, `bus_valid`, `timeout`), `hold_cnt` 0 and `last` NREQ-1.
  - An in-flight grant is abandoned, with no GAP cycle and no timeout pulse.

## Timing
- Grant latency: `req` is sampled in IDLE at cycle t; `gnt`, `owner`, `bus_valid` and `bus_out` are valid from cycle t+1.
- `bus_out` lags `data_in` of the owner by one cycle.
- A grant lasts between 1 and MAXHOLD cycles.
- Release: a condition true in cycle t gives GAP at t+1 (`gnt` = 0, `timeout` asserted if applicable) and IDLE at t+2. The earliest next grant is at t+3.
- Back-to-back owners are therefore separated by at least 2 cycles with `bus_valid` = 0.
- `timeout` is never high for more than one cycle and is never high outside GAP.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
Use NREQ=4, WIDTH=8, MAXHOLD=4.
- Reset: assert `rst` with random inputs -> `gnt`, `owner`, `bus_out`, `bus_valid` and `timeout` all 0 immediately, before any clock edge.
- Single requester: `req`=4'b0010 at cycle 0 and slice 1 = 8'hA5 -> at cycle 1 `gnt`=4'b0010, `owner`=1, `bus_out`=8'hA5; `done[1]`=1 at cycle 2 -> `gnt`=0 at cycle 3, IDLE at cycle 4.
- Fairness: `req`=4'b1111 held, with `done[owner]` pulsed on each grant's first cycle -> grant order 0,1,2,3,0, and `bus_valid` low for 2 cycles between grants.
- Timeout: `req`=4'b0100 held, `done`=0 -> `gnt`=4'b0100 for exactly 4 cycles, `timeout`=1 in the following GAP cycle, then regrant to 2 two cycles after release.
- Simultaneous events: `done[owner]`=1 in the cycle where `hold_cnt`=3 -> release with `timeout`=0. Separately, `req[owner]` dropped at the same point -> `timeout`=0.
- Reset mid-grant: assert `rst` while requester 2 is in BUSY, then release it with `req`=4'b1001 -> outputs clear immediately, and the first grant after reset goes to requester 0.
